demux_ctrl: RTL and testbench

DEMUX_CTRL -- requirements
Module: demux_ctrl

---
 rtl/demux_ctrl_pkg.sv | 6 +
 rtl/demux_ctrl_rr_pick.sv | 24 ++
 rtl/demux_ctrl.sv | 105 ++++++++++
 tb/tb_demux_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_ctrl_pkg.sv
// demux_ctrl_pkg: shared state, channel type and constants for the demux controller
package demux_ctrl_pkg;
  localparam int NUM_OUT = 4;
  typedef logic [$clog2(NUM_OUT)-1:0] ch_t;
  typedef enum logic [1:0] {IDLE, WAIT_RDY, DRIVE, DONE} state_t;
endpackage

// File: rtl/demux_ctrl_rr_pick.sv
// rr_pick: first unmasked channel in round-robin order starting after i_ptr
module rr_pick
  import demux_ctrl_pkg::*;
(
  input  ch_t                i_ptr,
  input  logic [NUM_OUT-1:0] i_mask,
  output ch_t                o_ch,
  output logic               o_valid
);
  ch_t w_c;
  // Scan from the farthest offset down so the nearest unmasked channel wins
  always_comb begin
    o_ch = '0;
    o_valid = 1'b0;
    w_c = '0;
    for (int k = NUM_OUT; k >= 1; k--) begin
      w_c = ch_t'(i_ptr + ch_t'(k));
      if (!i_mask[w_c]) begin
        o_ch = w_c;
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/demux_ctrl.sv
// demux_ctrl: round-robin dispatcher driving select/enable of an external 1-to-4 demux
module demux_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int PULSE_LEN = 1,
  parameter int TIMEOUT   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [NUM_OUT-1:0] skip_mask,
  input  logic [NUM_OUT-1:0] ch_ready,
  output logic [1:0]         sig,
  output logic               enable,
  output logic               busy,
  output logic               dispatch_done,
  output logic               timeout_err,
  output logic [1:0]         last_ch,
  output logic [7:0]         dispatch_cnt
);
  state_t     r_state, w_state_nxt;
  ch_t        r_ptr, w_ptr_nxt, r_sig, w_sig_nxt, r_last, w_last_nxt, w_pick;
  logic       r_en, w_en_nxt, r_done, w_done_nxt, r_to, w_to_nxt, w_valid;
  logic [7:0] r_cnt, w_cnt_nxt, r_wait, w_wait_nxt;
  logic [3:0] r_plen, w_plen_nxt;
  rr_pick u_pick (
    .i_ptr   (r_ptr),
    .i_mask  (skip_mask),
    .o_ch    (w_pick),
    .o_valid (w_valid)
  );
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sig_nxt   = r_sig;
    w_last_nxt  = r_last;
    w_en_nxt    = r_en;
    w_done_nxt  = 1'b0;
    w_to_nxt    = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_wait_nxt  = r_wait;
    w_plen_nxt  = r_plen;
    case (r_state)
      IDLE: if (req && w_valid) begin
        w_state_nxt = WAIT_RDY;
        w_sig_nxt   = w_pick;
        w_wait_nxt  = '0;
      end
      WAIT_RDY: if (ch_ready[r_sig]) begin
        w_state_nxt = DRIVE;
        w_en_nxt    = 1'b1;
        w_plen_nxt  = '0;
      end else if (r_wait == 8'(TIMEOUT - 1)) begin
        w_state_nxt = IDLE;
        w_to_nxt    = 1'b1;
        w_ptr_nxt   = r_sig;
      end else begin
        w_wait_nxt  = r_wait + 8'd1;
      end
      DRIVE: if (r_plen == 4'(PULSE_LEN - 1)) begin
        w_state_nxt = DONE;
        w_en_nxt    = 1'b0;
        w_done_nxt  = 1'b1;
        w_ptr_nxt   = r_sig;
        w_last_nxt  = r_sig;
        w_cnt_nxt   = r_cnt + 8'd1;
      end else begin
        w_plen_nxt  = r_plen + 4'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= ch_t'(NUM_OUT - 1);
      r_sig   <= '0;
      r_last  <= '0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
      r_to    <= 1'b0;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_plen  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sig   <= w_sig_nxt;
      r_last  <= w_last_nxt;
      r_en    <= w_en_nxt;
      r_done  <= w_done_nxt;
      r_to    <= w_to_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wait  <= w_wait_nxt;
      r_plen  <= w_plen_nxt;
    end
  end
  assign sig           = r_sig;
  assign enable        = r_en;
  assign busy          = (r_state != IDLE);
  assign dispatch_done = r_done;
  assign timeout_err   = r_to;
  assign last_ch       = r_last;
  assign dispatch_cnt  = r_cnt;
endmodule

// File: tb/tb_demux_ctrl.sv
// tb_demux_ctrl: randomized self-checking bench for demux_ctrl against a round-robin model
module tb_demux_ctrl;
  localparam int TO = 8;
  localparam int PB = 5;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_assert = 0, n_fail = 0;
  int m_ptr = 3, m_cnt = 0, m_last = 0;
  logic       a_rst_n, a_req, a_en, a_busy, a_done, a_to;
  logic [3:0] a_mask, a_rdy, a_dmx;
  logic [1:0] a_sig, a_last;
  logic [7:0] a_cnt;
  logic       b_rst_n, b_req, b_en, b_busy, b_done, b_to;
  logic [3:0] b_mask, b_rdy;
  logic [1:0] b_sig, b_last;
  logic [7:0] b_cnt;
  demux_ctrl #(.PULSE_LEN(1), .TIMEOUT(TO)) u_a (
    .clk(clk), .rst_n(a_rst_n), .req(a_req), .skip_mask(a_mask), .ch_ready(a_rdy),
    .sig(a_sig), .enable(a_en), .busy(a_busy), .dispatch_done(a_done),
    .timeout_err(a_to), .last_ch(a_last), .dispatch_cnt(a_cnt)
  );
  demux_ctrl #(.PULSE_LEN(PB), .TIMEOUT(TO)) u_b (
    .clk(clk), .rst_n(b_rst_n), .req(b_req), .skip_mask(b_mask), .ch_ready(b_rdy),
    .sig(b_sig), .enable(b_en), .busy(b_busy), .dispatch_done(b_done),
    .timeout_err(b_to), .last_ch(b_last), .dispatch_cnt(b_cnt)
  );
  // Top-level 1-to-4 demux: one-hot of the output currently enabled
  assign a_dmx = a_en ? 4'(1 << a_sig) : 4'b0;
  function automatic int pick(input int ptr, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) if (!m[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction
  logic       pa_en = 1'b0, pb_en = 1'b0;
  logic [1:0] pa_sig = 2'd0, pb_sig = 2'd0;
  always @(negedge clk) begin
    if (a_rst_n === 1'b1) begin
      n_assert++;
      if (a_sig !== pa_sig && (a_en || pa_en)) begin
        n_fail++; $display("FAIL sig_stable_a: sig %0d -> %0d with enable high", pa_sig, a_sig);
      end
    end
    if (b_rst_n === 1'b1) begin
      n_assert++;
      if (b_sig !== pb_sig && (b_en || pb_en)) begin
        n_fail++; $display("FAIL sig_stable_b: sig %0d -> %0d with enable high", pb_sig, b_sig);
      end
    end
    pa_en <= a_en; pa_sig <= a_sig; pb_en <= b_en; pb_sig <= b_sig;
  end
  task automatic reset_a();
    @(negedge clk); a_rst_n = 1'b0; a_req = 1'b0; a_mask = 4'h0; a_rdy = 4'h0;
    repeat (2) @(negedge clk);
    a_rst_n = 1'b1;
    m_ptr = 3; m_cnt = 0; m_last = 0;
  endtask
  task automatic test_reset();
    a_rst_n = 1'b0; a_req = 1'b0; a_mask = 4'h0; a_rdy = 4'h0;
    b_rst_n = 1'b0; b_req = 1'b0; b_mask = 4'h0; b_rdy = 4'h0;
    #1;
    n_assert++;
    if ({a_sig, a_en, a_busy, a_done, a_to, a_last, a_cnt} !== 16'h0) begin
      n_fail++; $display("FAIL reset_async: got %h want 0", {a_sig, a_en, a_busy, a_done, a_to, a_last, a_cnt});
    end
    @(negedge clk); a_rst_n = 1'b1; b_rst_n = 1'b1; a_req = 1'b1; a_rdy = 4'h0;
    @(posedge clk); #1;
    a_rst_n = 1'b0; #1;
    n_assert++;
    if ({a_sig, a_en, a_busy, a_done, a_to, a_last, a_cnt} !== 16'h0) begin
      n_fail++; $display("FAIL reset_mid_wait: got %h want 0", {a_sig, a_en, a_busy, a_done, a_to, a_last, a_cnt});
    end
    a_req = 1'b0;
    @(negedge clk); a_rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_assert++;
    if ({a_busy, a_en, a_sig} !== 4'b0) begin
      n_fail++; $display("FAIL reset_idle: got %b want 0000", {a_busy, a_en, a_sig});
    end
  endtask
  task automatic run_a(input logic [3:0] m, input logic [3:0] rdy);
    int e;
    e = pick(m_ptr, m);
    @(negedge clk); a_mask = m; a_rdy = rdy; a_req = 1'b1;
    @(posedge clk); #1;
    a_req = 1'b0; a_mask = 4'($urandom);
    n_assert++;
    if ({a_busy, a_en, a_sig} !== {1'b1, 1'b0, 2'(e)}) begin
      n_fail++; $display("FAIL accept: busy/en/sig %b want %b", {a_busy, a_en, a_sig}, {1'b1, 1'b0, 2'(e)});
    end
    if (rdy[e]) begin
      @(posedge clk); #1;
      a_rdy = 4'($urandom);
      n_assert++;
      if ({a_en, a_sig, a_done} !== {1'b1, 2'(e), 1'b0}) begin
        n_fail++; $display("FAIL drive: en/sig/done %b want %b", {a_en, a_sig, a_done}, {1'b1, 2'(e), 1'b0});
      end
      @(posedge clk); #1;
      m_cnt = (m_cnt + 1) % 256; m_last = e; m_ptr = e;
      n_assert++;
      if ({a_en, a_done, a_busy, a_cnt, a_last} !== {1'b0, 1'b1, 1'b1, 8'(m_cnt), 2'(m_last)}) begin
        n_fail++; $display("FAIL done: en/done/busy/cnt/last %h want %h", {a_en, a_done, a_busy, a_cnt, a_last},
                           {1'b0, 1'b1, 1'b1, 8'(m_cnt), 2'(m_last)});
      end
      @(posedge clk); #1;
      n_assert++;
      if ({a_busy, a_done, a_en} !== 3'b000) begin
        n_fail++; $display("FAIL back_idle: busy/done/en %b want 000", {a_busy, a_done, a_en});
      end
    end else begin
      for (int i = 1; i < TO; i++) begin
        @(posedge clk); #1;
        n_assert++;
        if ({a_busy, a_to, a_en} !== 3'b100) begin
          n_fail++; $display("FAIL waiting: cycle %0d busy/to/en %b want 100", i, {a_busy, a_to, a_en});
        end
      end
      @(posedge clk); #1;
      m_ptr = e;
      n_assert++;
      if ({a_busy, a_to, a_en, a_cnt} !== {3'b010, 8'(m_cnt)}) begin
        n_fail++; $display("FAIL timeout: busy/to/en/cnt %h want %h", {a_busy, a_to, a_en, a_cnt}, {3'b010, 8'(m_cnt)});
      end
      @(posedge clk); #1;
      n_assert++;
      if ({a_busy, a_to} !== 2'b00) begin
        n_fail++; $display("FAIL timeout_pulse: busy/to %b want 00", {a_busy, a_to});
      end
    end
  endtask
  task automatic run_held_a(input logic [3:0] m, input int n);
    int dones, run, e, budget;
    dones = 0; run = 0; e = 0; budget = n * 8 + 20;
    @(negedge clk); a_mask = m; a_rdy = 4'hF; a_req = 1'b1;
    while (dones < n && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      if (a_en) begin
        if (run == 0) begin
          e = pick(m_ptr, m);
          n_assert++;
          if (a_sig !== 2'(e)) begin
            n_fail++; $display("FAIL held_sig: sig %0d want %0d", a_sig, e);
          end
        end
        run++;
        n_assert++;
        if ((a_dmx & m) !== 4'b0) begin
          n_fail++; $display("FAIL masked_enabled: demux %b mask %b want no overlap", a_dmx, m);
        end
      end else if (run > 0) begin
        n_assert++;
        if (run != 1) begin
          n_fail++; $display("FAIL pulse_len: %0d cycles want 1", run);
        end
        run = 0;
      end
      if (a_done) begin
        m_cnt = (m_cnt + 1) % 256; m_last = e; m_ptr = e; dones++;
        n_assert++;
        if ({a_cnt, a_last} !== {8'(m_cnt), 2'(m_last)}) begin
          n_fail++; $display("FAIL held_done: cnt %0d last %0d want %0d %0d", a_cnt, a_last, m_cnt, m_last);
        end
        if (dones == n) a_req = 1'b0;
      end
    end
    n_assert++;
    if (dones != n) begin
      n_fail++; $display("FAIL held_budget: %0d dispatches want %0d", dones, n);
    end
    @(posedge clk); #1;
    n_assert++;
    if (a_busy !== 1'b0) begin
      n_fail++; $display("FAIL held_idle: busy %b want 0", a_busy);
    end
  endtask
  task automatic test_round_robin();
    reset_a();
    run_held_a(4'h0, 4);
    n_assert++;
    if ({a_cnt, a_last} !== {8'd4, 2'd3}) begin
      n_fail++; $display("FAIL rr_final: cnt %0d last %0d want 4 3", a_cnt, a_last);
    end
  endtask
  task automatic test_mask();
    reset_a();
    run_held_a(4'b0101, 4);
    n_assert++;
    if ({a_cnt, a_last} !== {8'd4, 2'd3}) begin
      n_fail++; $display("FAIL mask_final: cnt %0d last %0d want 4 3", a_cnt, a_last);
    end
  endtask
  task automatic test_timeout();
    reset_a();
    run_a(4'h0, 4'b1110);
    run_a(4'h0, 4'hF);
    n_assert++;
    if ({a_cnt, a_last} !== {8'd1, 2'd1}) begin
      n_fail++; $display("FAIL after_timeout: cnt %0d last %0d want 1 1", a_cnt, a_last);
    end
  endtask
  task automatic test_all_masked();
    logic [1:0] s;
    s = a_sig;
    @(negedge clk); a_mask = 4'hF; a_rdy = 4'hF; a_req = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      n_assert++;
      if ({a_busy, a_en, a_sig} !== {2'b00, s}) begin
        n_fail++; $display("FAIL all_masked: busy/en/sig %b want %b", {a_busy, a_en, a_sig}, {2'b00, s});
      end
    end
    a_req = 1'b0;
  endtask
  task automatic test_random();
    logic [3:0] m;
    for (int i = 0; i < 40; i++) begin
      m = 4'($urandom);
      if (m == 4'hF) m = 4'($urandom_range(0, 14));
      run_a(m, 4'($urandom));
    end
  endtask
  task automatic test_back_to_back_wrap();
    reset_a();
    run_held_a(4'h0, 255);
    n_assert++;
    if (a_cnt !== 8'd255) begin
      n_fail++; $display("FAIL cnt_255: cnt %0d want 255", a_cnt);
    end
    run_held_a(4'h0, 1);
    n_assert++;
    if (a_cnt !== 8'd0) begin
      n_fail++; $display("FAIL cnt_wrap: cnt %0d want 0", a_cnt);
    end
  endtask
  task automatic test_pulse_reset();
    @(negedge clk); b_rst_n = 1'b0; b_req = 1'b0; b_mask = 4'h0; b_rdy = 4'hF;
    @(negedge clk); b_rst_n = 1'b1; b_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if ({b_en, b_sig} !== 3'b100) begin
      n_fail++; $display("FAIL drive3: en/sig %b want 100", {b_en, b_sig});
    end
    #2 b_rst_n = 1'b0;
    #1;
    n_assert++;
    if ({b_en, b_busy, b_done, b_cnt} !== 11'h0) begin
      n_fail++; $display("FAIL reset_drive: en/busy/done/cnt %h want 0", {b_en, b_busy, b_done, b_cnt});
    end
    repeat (3) begin
      @(posedge clk); #1;
      n_assert++;
      if ({b_done, b_cnt} !== 9'h0) begin
        n_fail++; $display("FAIL no_done: done/cnt %h want 0", {b_done, b_cnt});
      end
    end
    @(negedge clk); b_rst_n = 1'b1;
    @(posedge clk); #1;
    b_req = 1'b0;
    n_assert++;
    if ({b_busy, b_en, b_sig} !== 4'b1000) begin
      n_fail++; $display("FAIL first_pick: busy/en/sig %b want 1000", {b_busy, b_en, b_sig});
    end
    for (int i = 1; i <= PB; i++) begin
      @(posedge clk); #1;
      n_assert++;
      if ({b_en, b_done} !== 2'b10) begin
        n_fail++; $display("FAIL pulse5: edge %0d en/done %b want 10", i, {b_en, b_done});
      end
    end
    @(posedge clk); #1;
    n_assert++;
    if ({b_en, b_done, b_busy, b_cnt, b_last} !== {3'b011, 8'd1, 2'd0}) begin
      n_fail++; $display("FAIL done5: en/done/busy/cnt/last %h want %h", {b_en, b_done, b_busy, b_cnt, b_last},
                         {3'b011, 8'd1, 2'd0});
    end
    @(posedge clk); #1;
    n_assert++;
    if ({b_busy, b_done} !== 2'b00) begin
      n_fail++; $display("FAIL idle5: busy/done %b want 00", {b_busy, b_done});
    end
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_mask();
    test_timeout();
    test_all_masked();
    test_random();
    test_back_to_back_wrap();
    test_pulse_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
